enc8b10b_tx: RTL and testbench

ENC8B10B_TX -- requirements
Module: enc8b10b_tx

---
 rtl/tdc_8b10b_pkg.sv | 27 ++
 rtl/enc8b10b_lut.sv | 116 +++++++++++
 rtl/enc8b10b_tx.sv | 111 +++++++++++
 tb/tb_enc8b10b_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tdc_8b10b_pkg.sv
// Shared definitions for the 8b/10b transmit path: FSM states, the K28.5
// comma byte and the set of control codes the encoder is allowed to emit.
package tdc_8b10b_pkg;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_t;

    localparam logic [7:0] K28_5 = 8'hBC;

    localparam int N_LEGAL_K = 12;
    localparam logic [7:0] LEGAL_K [N_LEGAL_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_legal_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LEGAL_K; i++) begin
            if (b == LEGAL_K[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/enc8b10b_lut.sv
// Combinational 8b/10b code-group lookup (abcdei fghj, a at bit 9) with
// running-disparity tracking across the 6b and 4b sub-blocks.
module enc8b10b_lut
    import tdc_8b10b_pkg::*;
(
    input  logic [7:0] din,
    input  logic       kin,
    input  logic       rd_neg_in,
    output logic [9:0] code,
    output logic       rd_neg_out,
    output logic       k_err
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k_ok;
    logic       k28;
    logic [5:0] c6_neg;
    logic [5:0] c6;
    logic       comp6;
    logic       rd6_neg;
    logic [3:0] c4_neg;
    logic [3:0] c4;
    logic       comp4;
    logic       use_a7;

    assign x     = din[4:0];
    assign y     = din[7:5];
    assign k_ok  = kin & is_legal_k(din);
    assign k_err = kin & ~k_ok;
    assign k28   = k_ok && (x == 5'd28);

    always_comb begin
        c6_neg = 6'b000000;
        case (x)
            5'd0:  c6_neg = 6'b100111;
            5'd1:  c6_neg = 6'b011101;
            5'd2:  c6_neg = 6'b101101;
            5'd3:  c6_neg = 6'b110001;
            5'd4:  c6_neg = 6'b110101;
            5'd5:  c6_neg = 6'b101001;
            5'd6:  c6_neg = 6'b011001;
            5'd7:  c6_neg = 6'b111000;
            5'd8:  c6_neg = 6'b111001;
            5'd9:  c6_neg = 6'b100101;
            5'd10: c6_neg = 6'b010101;
            5'd11: c6_neg = 6'b110100;
            5'd12: c6_neg = 6'b001101;
            5'd13: c6_neg = 6'b101100;
            5'd14: c6_neg = 6'b011100;
            5'd15: c6_neg = 6'b010111;
            5'd16: c6_neg = 6'b011011;
            5'd17: c6_neg = 6'b100011;
            5'd18: c6_neg = 6'b010011;
            5'd19: c6_neg = 6'b110010;
            5'd20: c6_neg = 6'b001011;
            5'd21: c6_neg = 6'b101010;
            5'd22: c6_neg = 6'b011010;
            5'd23: c6_neg = 6'b111010;
            5'd24: c6_neg = 6'b110011;
            5'd25: c6_neg = 6'b100110;
            5'd26: c6_neg = 6'b010110;
            5'd27: c6_neg = 6'b110110;
            5'd28: c6_neg = k28 ? 6'b001111 : 6'b001110;
            5'd29: c6_neg = 6'b101110;
            5'd30: c6_neg = 6'b011110;
            default: c6_neg = 6'b101011;
        endcase

        // Unbalanced codes and D.7 (111000/000111) invert at positive disparity.
        comp6 = ($countones(c6_neg) != 3) || (x == 5'd7);
        c6    = (!rd_neg_in && comp6) ? ~c6_neg : c6_neg;
        if ($countones(c6) > 3)      rd6_neg = 1'b0;
        else if ($countones(c6) < 3) rd6_neg = 1'b1;
        else                         rd6_neg = rd_neg_in;

        use_a7 = k_ok
              || ( rd6_neg && (x == 5'd17 || x == 5'd18 || x == 5'd20))
              || (!rd6_neg && (x == 5'd11 || x == 5'd13 || x == 5'd14));

        c4_neg = 4'b0000;
        comp4  = 1'b1;
        if (k28) begin
            case (y)
                3'd0:    c4_neg = 4'b1011;
                3'd1:    c4_neg = 4'b0110;
                3'd2:    c4_neg = 4'b1010;
                3'd3:    c4_neg = 4'b1100;
                3'd4:    c4_neg = 4'b1101;
                3'd5:    c4_neg = 4'b0101;
                3'd6:    c4_neg = 4'b1001;
                default: c4_neg = 4'b0111;
            endcase
        end else begin
            case (y)
                3'd0:    c4_neg = 4'b1011;
                3'd1:    c4_neg = 4'b1001;
                3'd2:    c4_neg = 4'b0101;
                3'd3:    c4_neg = 4'b1100;
                3'd4:    c4_neg = 4'b1101;
                3'd5:    c4_neg = 4'b1010;
                3'd6:    c4_neg = 4'b0110;
                default: c4_neg = use_a7 ? 4'b0111 : 4'b1110;
            endcase
            comp4 = ($countones(c4_neg) != 2) || (y == 3'd3);
        end

        c4 = (!rd6_neg && comp4) ? ~c4_neg : c4_neg;
        if ($countones(c4) > 2)      rd_neg_out = 1'b0;
        else if ($countones(c4) < 2) rd_neg_out = 1'b1;
        else                         rd_neg_out = rd6_neg;

        code = {c6, c4};
    end

endmodule

// File: rtl/enc8b10b_tx.sv
// 8b/10b transmitter: sends SYNC_WORDS K28.5 commas after reset, then encodes
// byte/K pairs with one cycle of latency. Define ENC8B10B_IDLE_COMMA_EN to fill idle cycles with K28.5.
module enc8b10b_tx
    import tdc_8b10b_pkg::*;
#(
    parameter int SYNC_WORDS = 16
) (
    input  logic       i_Clk,
    input  logic       i_ARst_L,
    input  logic       soft_reset_i,
    input  logic [7:0] i8_Din,
    input  logic       i_Kin,
    input  logic       i_Valid,
    output logic       o_Ready,
    output logic [9:0] o10_Dout,
    output logic       o_Valid,
    output logic       o_KErr,
    output logic       o_Rd
);

    localparam logic [7:0] SYNC_LOAD = 8'(SYNC_WORDS);

    enc_state_t state_reg;
    logic [7:0] cnt_reg;
    logic       rd_neg_reg;
    logic [9:0] dout_reg;
    logic       valid_reg;
    logic       kerr_reg;
    logic       ready_reg;

    logic       transfer;
    logic       use_comma;
    logic [7:0] lut_din;
    logic       lut_k;
    logic [9:0] lut_code;
    logic       lut_rd_neg;
    logic       lut_kerr;

    assign transfer  = ready_reg & i_Valid;
    assign use_comma = (state_reg == ST_SYNC) || !transfer;
    assign lut_din   = use_comma ? K28_5 : i8_Din;
    assign lut_k     = use_comma ? 1'b1  : i_Kin;

    enc8b10b_lut u_lut (
        .din        (lut_din),
        .kin        (lut_k),
        .rd_neg_in  (rd_neg_reg),
        .code       (lut_code),
        .rd_neg_out (lut_rd_neg),
        .k_err      (lut_kerr)
    );

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state_reg  <= ST_SYNC;
            cnt_reg    <= SYNC_LOAD;
            rd_neg_reg <= 1'b1;
            dout_reg   <= '0;
            valid_reg  <= 1'b0;
            kerr_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else if (soft_reset_i) begin
            state_reg  <= ST_SYNC;
            cnt_reg    <= SYNC_LOAD;
            rd_neg_reg <= 1'b1;
            dout_reg   <= '0;
            valid_reg  <= 1'b0;
            kerr_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_SYNC: begin
                    dout_reg   <= lut_code;
                    rd_neg_reg <= lut_rd_neg;
                    valid_reg  <= 1'b1;
                    kerr_reg   <= 1'b0;
                    ready_reg  <= 1'b0;
                    cnt_reg    <= cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) state_reg <= ST_RUN;
                end
                default: begin
                    // Ready is registered, so it rises the cycle after entering RUN.
                    ready_reg <= 1'b1;
                    if (transfer) begin
                        dout_reg   <= lut_code;
                        rd_neg_reg <= lut_rd_neg;
                        valid_reg  <= 1'b1;
                        kerr_reg   <= lut_kerr;
                    end else begin
`ifdef ENC8B10B_IDLE_COMMA_EN
                        dout_reg   <= lut_code;
                        rd_neg_reg <= lut_rd_neg;
                        valid_reg  <= 1'b1;
                        kerr_reg   <= 1'b0;
`else
                        valid_reg  <= 1'b0;
                        kerr_reg   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign o_Ready  = ready_reg;
    assign o10_Dout = dout_reg;
    assign o_Valid  = valid_reg;
    assign o_KErr   = kerr_reg;
    assign o_Rd     = rd_neg_reg;

endmodule

// File: tb/tb_enc8b10b_tx.sv
// Directed testbench for enc8b10b_tx with SYNC_WORDS=4.
module tb_enc8b10b_tx;

    logic       i_Clk = 1'b0;
    logic       i_ARst_L;
    logic       soft_reset_i;
    logic [7:0] i8_Din;
    logic       i_Kin;
    logic       i_Valid;
    logic       o_Ready;
    logic [9:0] o10_Dout;
    logic       o_Valid;
    logic       o_KErr;
    logic       o_Rd;

    always #5 i_Clk = ~i_Clk;

    enc8b10b_tx #(.SYNC_WORDS(4)) dut (
        .i_Clk        (i_Clk),
        .i_ARst_L     (i_ARst_L),
        .soft_reset_i (soft_reset_i),
        .i8_Din       (i8_Din),
        .i_Kin        (i_Kin),
        .i_Valid      (i_Valid),
        .o_Ready      (o_Ready),
        .o10_Dout     (o10_Dout),
        .o_Valid      (o_Valid),
        .o_KErr       (o_KErr),
        .o_Rd         (o_Rd)
    );

    typedef struct {
        logic [7:0] din;
        logic       k;
        logic [9:0] code;
        logic       rd;
        logic       kerr;
    } vec_t;

    localparam logic [9:0] COMMA_N = 10'b0011111010;
    localparam logic [9:0] COMMA_P = 10'b1100000101;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [14];

    task automatic chk(input string nm, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    // Four sync commas (inputs offered but ignored), then o_Ready on the fifth edge.
    task automatic sync_seq(input string tag);
        i_Valid = 1'b1;
        i8_Din  = 8'h00;
        i_Kin   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            $display("%s sync %0d dout=%b valid=%b ready=%b rd=%b", tag, i, o10_Dout, o_Valid, o_Ready, o_Rd);
            chk({tag, "_sync_valid"}, 10'(o_Valid), 10'd1);
            chk({tag, "_sync_dout"}, o10_Dout, (i % 2 == 0) ? COMMA_N : COMMA_P);
            chk({tag, "_sync_ready"}, 10'(o_Ready), 10'd0);
        end
        chk({tag, "_sync_rd_end"}, 10'(o_Rd), 10'd1);
        @(negedge i_Clk);
        $display("%s post-sync ready=%b valid=%b", tag, o_Ready, o_Valid);
        chk({tag, "_ready_rise"}, 10'(o_Ready), 10'd1);
`ifdef ENC8B10B_IDLE_COMMA_EN
        // Gap cycle emitted one idle comma; one more returns RD to negative.
        chk({tag, "_gap_comma"}, o10_Dout, COMMA_N);
        i_Valid = 1'b0;
        @(negedge i_Clk);
        chk({tag, "_gap_comma2"}, o10_Dout, COMMA_P);
`else
        chk({tag, "_gap_valid"}, 10'(o_Valid), 10'd0);
`endif
    endtask

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 10'b1001110100, 1'b1, 1'b0}; // D0.0
        vecs[1]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0}; // D21.5
        vecs[2]  = '{8'hF1, 1'b0, 10'b1000110111, 1'b0, 1'b0}; // D17.7 A7 at RD-
        vecs[3]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b1, 1'b0}; // K28.5 at RD+
        vecs[4]  = '{8'h01, 1'b1, 10'b0111010100, 1'b1, 1'b1}; // illegal K -> D1.0
        vecs[5]  = '{8'hBC, 1'b1, 10'b0011111010, 1'b0, 1'b0}; // K28.5 at RD-
        vecs[6]  = '{8'hF7, 1'b1, 10'b0001010111, 1'b0, 1'b0}; // K23.7 at RD+
        vecs[7]  = '{8'hEB, 1'b0, 10'b1101001000, 1'b1, 1'b0}; // D11.7 A7 at RD+
        vecs[8]  = '{8'h63, 1'b0, 10'b1100011100, 1'b1, 1'b0}; // D3.3
        vecs[9]  = '{8'h27, 1'b0, 10'b1110001001, 1'b1, 1'b0}; // D7.1 at RD-
        vecs[10] = '{8'hF4, 1'b0, 10'b0010110111, 1'b0, 1'b0}; // D20.7 A7 at RD-
        vecs[11] = '{8'h07, 1'b0, 10'b0001110100, 1'b1, 1'b0}; // D7.0 at RD+
        vecs[12] = '{8'hFC, 1'b1, 10'b0011111000, 1'b1, 1'b0}; // K28.7
        vecs[13] = '{8'h9F, 1'b0, 10'b1010110010, 1'b1, 1'b0}; // D31.4

        i_ARst_L     = 1'b0;
        soft_reset_i = 1'b0;
        i8_Din       = 8'h00;
        i_Kin        = 1'b0;
        i_Valid      = 1'b0;
        repeat (3) @(negedge i_Clk);
        $display("reset dout=%b valid=%b ready=%b kerr=%b rd=%b", o10_Dout, o_Valid, o_Ready, o_KErr, o_Rd);
        chk("rst_dout", o10_Dout, 10'd0);
        chk("rst_valid", 10'(o_Valid), 10'd0);
        chk("rst_ready", 10'(o_Ready), 10'd0);
        chk("rst_kerr", 10'(o_KErr), 10'd0);
        chk("rst_rd", 10'(o_Rd), 10'd1);
        i_ARst_L = 1'b1;

        sync_seq("por");

        for (int i = 0; i < 14; i++) begin
            i8_Din  = vecs[i].din;
            i_Kin   = vecs[i].k;
            i_Valid = 1'b1;
            @(negedge i_Clk);
            $display("vec %0d din=%h k=%b dout=%b rd=%b kerr=%b valid=%b", i, vecs[i].din, vecs[i].k, o10_Dout, o_Rd, o_KErr, o_Valid);
            chk($sformatf("vec%0d_valid", i), 10'(o_Valid), 10'd1);
            chk($sformatf("vec%0d_dout", i), o10_Dout, vecs[i].code);
            chk($sformatf("vec%0d_rd", i), 10'(o_Rd), 10'(vecs[i].rd));
            chk($sformatf("vec%0d_kerr", i), 10'(o_KErr), 10'(vecs[i].kerr));
        end

        // Idle cycles in RUN.
        i_Valid = 1'b0;
        i8_Din  = 8'h55;
        i_Kin   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            $display("idle %0d dout=%b valid=%b rd=%b", i, o10_Dout, o_Valid, o_Rd);
`ifdef ENC8B10B_IDLE_COMMA_EN
            chk("idle_valid", 10'(o_Valid), 10'd1);
            chk("idle_dout", o10_Dout, (i % 2 == 0) ? COMMA_N : COMMA_P);
            chk("idle_rd", 10'(o_Rd), (i % 2 == 0) ? 10'd0 : 10'd1);
`else
            chk("idle_valid", 10'(o_Valid), 10'd0);
            chk("idle_dout_held", o10_Dout, 10'b1010110010);
            chk("idle_rd", 10'(o_Rd), 10'd1);
`endif
        end

        // Leave RD positive, then soft reset against a pending transfer.
        i8_Din  = 8'hBC;
        i_Kin   = 1'b1;
        i_Valid = 1'b1;
        @(negedge i_Clk);
        $display("pre-srst dout=%b rd=%b", o10_Dout, o_Rd);
        chk("presrst_dout", o10_Dout, COMMA_N);
        chk("presrst_rd", 10'(o_Rd), 10'd0);
        soft_reset_i = 1'b1;
        @(negedge i_Clk);
        $display("srst dout=%b valid=%b ready=%b rd=%b", o10_Dout, o_Valid, o_Ready, o_Rd);
        chk("srst_valid", 10'(o_Valid), 10'd0);
        chk("srst_ready", 10'(o_Ready), 10'd0);
        chk("srst_rd", 10'(o_Rd), 10'd1);
        chk("srst_dout", o10_Dout, 10'd0);
        soft_reset_i = 1'b0;

        sync_seq("srst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
